coef_bank: RTL and testbench
============================

# coef_bank

Parametrised, runtime-reloadable FIR coefficient store for the acoustic filter datapath. It holds `N_SETS` selectable coefficient sets, with optional symmetric folding that stores only half of a linear-phase response. New coefficients are loaded into a shadow page and swapped in only at a frame boundary, so a convolution never sees mixed coefficients. It sits between the control/host side (load port) and the FIR MAC (synchronous read port, 1-cycle latency).

## Interface
- `COEF_W`, 16: signed coefficient width.
- `ORDER`, 39: filter order; `TAPS = ORDER+1`.
- `ADDR_W`, 6: tap address width; must satisfy `2**ADDR_W >= TAPS`.
- `N_SETS`, 4: number of coefficient sets; `SET_W = max(1, $clog2(N_SETS))`.
- `SYMMETRIC`, 1: 1 stores `STORE_N = (TAPS+1)/2` entries per set and mirrors them; 0 stores `STORE_N = TAPS` entries.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_en` in 1: read strobe.
- `rd_set` in SET_W: set to read.
- `rd_addr` in ADDR_W: tap index 0..ORDER.
- `coef_bits` out COEF_W signed: registered coefficient.
- `frame_start` in 1: pulse from the MAC marking the first tap read of a new output sample.
- `ld_valid` in 1, `ld_ready` out 1: load handshake.
- `ld_set` in SET_W, `ld_addr` in ADDR_W, `ld_data` in COEF_W signed: load payload. `ld_addr` is in stored-index space, 0..STORE_N-1.
- `commit` in 1: pulse requesting a page swap.
- `busy` out 1: high in PENDING or COPY.
- `active_page` out 1: page currently being read.
- `swap_done` out 1: 1-cycle pulse when the copy-back finishes.

## Operation
- Storage consists of two pages, each `N_SETS × STORE_N` entries. Both pages, for every set, are initialised at configuration to the package default (the 40-tap bandpass). `reset` does not modify memory contents.
- Read index:
  - SYMMETRIC=1: `idx = min(rd_addr, ORDER-rd_addr)`.
  - SYMMETRIC=0: `idx = rd_addr`.
  - `rd_addr > ORDER` or `rd_set >= N_SETS` returns 0.
  - Reads always come from the active page.
- `coef_bits` updates only when `rd_en` is high; otherwise it holds its value.
- FSM states:
  - IDLE: `ld_ready=1`. A handshake (`ld_valid & ld_ready`) writes `ld_data` to shadow[`ld_set`][`ld_addr`]; out-of-range `ld_set` or `ld_addr` is accepted and dropped. `commit` moves to PENDING.
  - PENDING: `ld_ready=0`. On the first `frame_start` seen in this state, `active_page` toggles; move to COPY.
  - COPY: `ld_ready=0`. Copies one entry per cycle from the new active page into the new shadow page, `N_SETS*STORE_N` cycles, so later partial loads build on current contents. On the last entry, pulse `swap_done` and move to IDLE.
- Load and `commit` in the same IDLE cycle: the write lands, then the FSM enters PENDING.
- `commit` outside IDLE is ignored.
- `frame_start` in the same cycle as `commit` does not swap. The swap needs a `frame_start` while already in PENDING.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N+1.
- The swap takes effect at the edge where `frame_start` is sampled in PENDING. A read issued in that same cycle returns old-page data; reads issued from the next cycle return new-page data.
- Load write is visible in the shadow page from the cycle after the handshake.
- COPY duration is exactly `N_SETS*STORE_N` cycles. `swap_done` is asserted in the cycle after the last copy write. `busy` falls in that same cycle.
- Reset values: `coef_bits=0`, `active_page=0`, `busy=0`, `swap_done=0`, `ld_ready=1` (state IDLE).
- Reset during PENDING or COPY aborts to IDLE with `active_page=0`. A partially copied shadow page is left as is.

## Structure
- Package `coef_pkg`:
  - default parameter constants;
  - the FSM state enum `{IDLE, PENDING, COPY}`;
  - a localparam array of the 20 unique default values: −360, −383, −550, −730, −906, −1061, −1173, −1222, −1193, −1073, −858, −552, −168, 272, 741, 1206, 1631, 1984, 2237, 2369;
  - a function `fold_idx(addr)`.
- One sub-module `coef_page_ram`: one page with one write port, two read ports (datapath and copy), and default initialisation. It is instantiated twice.

## Test plan
- Default read, set 0: `rd_addr` 0, 19, 20, 39, 40 → `coef_bits` −360, 2369, 2369, −360, 0, each one cycle after its address.
- Load set 1, `ld_addr=0`, `ld_data=1000`, then `commit`, then `frame_start`: reads of set 1 at addr 0 and addr 39 return 1000. Set 0 is unchanged (−360).
- Read issued in the `frame_start` swap cycle returns the old value. The read one cycle later returns the new value.
- After a swap, measure from the swap edge: `busy` stays high for 80 cycles (4×20), `swap_done` pulses once, `ld_ready` returns to 1. A subsequent load to set 1 addr 1 with `commit`/`frame_start` leaves addr 0 at 1000.
- `ld_valid` during PENDING is not accepted (`ld_ready=0`). `commit` together with `frame_start` in IDLE does not swap.
- Reset asserted mid-COPY → next cycle: `busy=0`, `active_page=0`, `ld_ready=1`, `coef_bits=0`.

Source files
------------

// File: rtl/coef_pkg.sv
// Shared constants, FSM state type and index helpers for the coefficient bank.
package coef_pkg;

    localparam int DEF_COEF_W    = 16;
    localparam int DEF_ORDER     = 39;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_N_SETS    = 4;
    localparam int DEF_SYMMETRIC = 1;

    // Unique half of the default 40-tap linear-phase bandpass response.
    localparam int DEF_UNIQUE_N = 20;
    localparam logic signed [15:0] DEF_UNIQUE [DEF_UNIQUE_N] = '{
        -16'sd360,  -16'sd383,  -16'sd550,  -16'sd730,  -16'sd906,
        -16'sd1061, -16'sd1173, -16'sd1222, -16'sd1193, -16'sd1073,
        -16'sd858,  -16'sd552,  -16'sd168,   16'sd272,   16'sd741,
         16'sd1206,  16'sd1631,  16'sd1984,  16'sd2237,  16'sd2369
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } coef_state_e;

    // Mirror a tap index onto the stored half of a symmetric response.
    function automatic int fold_idx(input int addr, input int order = DEF_ORDER);
        return (addr <= order - addr) ? addr : order - addr;
    endfunction

    // Default coefficient for stored index k (same table for folded and full storage).
    function automatic int default_tap(input int k);
        if (k < DEF_UNIQUE_N)
            return int'(DEF_UNIQUE[k]);
        else if (k < 2 * DEF_UNIQUE_N)
            return int'(DEF_UNIQUE[2 * DEF_UNIQUE_N - 1 - k]);
        else
            return 0;
    endfunction

endpackage

// File: rtl/coef_bank_if.sv
// Read, load and page-swap signals between host/MAC (master) and the bank (slave).
// Load handshake: a word transfers on a rising clk edge where ld_valid and
// ld_ready are both high; ld_set/ld_addr/ld_data must be stable while ld_valid
// is high, and ld_ready does not depend combinationally on ld_valid.
interface coef_bank_if #(
    parameter int COEF_W = 16,
    parameter int ADDR_W = 6,
    parameter int SET_W  = 2
);
    logic                     rd_en;
    logic [SET_W-1:0]         rd_set;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [COEF_W-1:0] coef_bits;
    logic                     frame_start;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [SET_W-1:0]         ld_set;
    logic [ADDR_W-1:0]        ld_addr;
    logic signed [COEF_W-1:0] ld_data;
    logic                     commit;
    logic                     busy;
    logic                     active_page;
    logic                     swap_done;

    modport master (
        output rd_en, rd_set, rd_addr, frame_start,
        output ld_valid, ld_set, ld_addr, ld_data, commit,
        input  coef_bits, ld_ready, busy, active_page, swap_done
    );

    modport slave (
        input  rd_en, rd_set, rd_addr, frame_start,
        input  ld_valid, ld_set, ld_addr, ld_data, commit,
        output coef_bits, ld_ready, busy, active_page, swap_done
    );
endinterface

// File: rtl/coef_page_ram.sv
// One coefficient page: one write port, asynchronous datapath and copy read ports,
// contents preloaded with the default response for every set.
module coef_page_ram
    import coef_pkg::*;
#(
    parameter int COEF_W  = 16,
    parameter int N_SETS  = 4,
    parameter int STORE_N = 20,
    parameter int DEPTH   = N_SETS * STORE_N,
    parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [COEF_W-1:0] wdata,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [COEF_W-1:0] rd_data,
    input  logic [AW-1:0]            cp_addr,
    output logic signed [COEF_W-1:0] cp_data
);

    typedef logic signed [COEF_W-1:0] mem_t [DEPTH];

    function automatic mem_t default_image();
        mem_t img;
        for (int s = 0; s < N_SETS; s++)
            for (int k = 0; k < STORE_N; k++)
                img[s * STORE_N + k] = COEF_W'(default_tap(k));
        return img;
    endfunction

    // Configuration-time contents; reset never touches the array.
    mem_t mem = default_image();

    // Single write port shared by host loads and copy-back.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rd_data = mem[rd_addr];
    assign cp_data = mem[cp_addr];

endmodule

// File: rtl/coef_bank.sv
// Double-buffered FIR coefficient store: host loads the shadow page, a commit swaps
// pages on the next frame boundary, then the new active page is copied back into
// the shadow so later partial loads build on current contents.
module coef_bank
    import coef_pkg::*;
#(
    parameter int COEF_W    = DEF_COEF_W,
    parameter int ORDER     = DEF_ORDER,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int N_SETS    = DEF_N_SETS,
    parameter int SYMMETRIC = DEF_SYMMETRIC,
    parameter int SET_W     = (N_SETS > 1) ? $clog2(N_SETS) : 1
) (
    input  logic        clk,
    input  logic        reset,
    coef_bank_if.slave  bus,
    output coef_state_e state_dbg
);

    localparam int TAPS    = ORDER + 1;
    localparam int STORE_N = (SYMMETRIC != 0) ? (TAPS + 1) / 2 : TAPS;
    localparam int DEPTH   = N_SETS * STORE_N;
    localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    coef_state_e              state, state_next;
    logic                     swap_next;
    logic                     swap_done;
    logic                     active_page;
    logic [MEM_AW-1:0]        copy_cnt;
    logic signed [COEF_W-1:0] coef_bits;

    logic                     rd_hit, ld_hit;
    logic [MEM_AW-1:0]        rd_index, ld_index, waddr;
    logic signed [COEF_W-1:0] rd_data0, rd_data1, cp_data0, cp_data1;
    logic signed [COEF_W-1:0] rd_word, cp_word, wdata;
    logic                     load_wr, copy_wr, we0, we1;

    // Map tap address to stored index; out-of-range taps or sets read as zero.
    always_comb begin
        rd_hit   = 1'b0;
        rd_index = '0;
        if (int'(bus.rd_addr) <= ORDER && int'(bus.rd_set) < N_SETS) begin
            rd_hit   = 1'b1;
            rd_index = MEM_AW'(int'(bus.rd_set) * STORE_N +
                       ((SYMMETRIC != 0) ? fold_idx(int'(bus.rd_addr), ORDER)
                                         : int'(bus.rd_addr)));
        end
    end

    // Load address check; out-of-range loads are handshaken but discarded.
    always_comb begin
        ld_hit   = 1'b0;
        ld_index = '0;
        if (int'(bus.ld_set) < N_SETS && int'(bus.ld_addr) < STORE_N) begin
            ld_hit   = 1'b1;
            ld_index = MEM_AW'(int'(bus.ld_set) * STORE_N + int'(bus.ld_addr));
        end
    end

    assign rd_word = active_page ? rd_data1 : rd_data0;
    assign cp_word = active_page ? cp_data1 : cp_data0;

    // Writes always target the shadow page (the one not being read).
    assign load_wr = (state == IDLE) && bus.ld_valid && ld_hit;
    assign copy_wr = (state == COPY);
    assign waddr   = copy_wr ? copy_cnt : ld_index;
    assign wdata   = copy_wr ? cp_word : bus.ld_data;
    assign we0     = (load_wr || copy_wr) && active_page;
    assign we1     = (load_wr || copy_wr) && !active_page;

    coef_page_ram #(.COEF_W(COEF_W), .N_SETS(N_SETS), .STORE_N(STORE_N),
                    .DEPTH(DEPTH), .AW(MEM_AW)) u_page0 (
        .clk(clk), .we(we0), .waddr(waddr), .wdata(wdata),
        .rd_addr(rd_index), .rd_data(rd_data0),
        .cp_addr(copy_cnt), .cp_data(cp_data0)
    );

    coef_page_ram #(.COEF_W(COEF_W), .N_SETS(N_SETS), .STORE_N(STORE_N),
                    .DEPTH(DEPTH), .AW(MEM_AW)) u_page1 (
        .clk(clk), .we(we1), .waddr(waddr), .wdata(wdata),
        .rd_addr(rd_index), .rd_data(rd_data1),
        .cp_addr(copy_cnt), .cp_data(cp_data1)
    );

    // Next-state logic: commit arms the swap, frame_start fires it, copy-back ends it.
    always_comb begin
        state_next = state;
        swap_next  = 1'b0;
        case (state)
            IDLE:    if (bus.commit) state_next = PENDING;
            PENDING: if (bus.frame_start) state_next = COPY;
            COPY: begin
                if (copy_cnt == MEM_AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                    swap_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, page select, copy pointer and completion pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            swap_done   <= 1'b0;
            active_page <= 1'b0;
            copy_cnt    <= '0;
        end else begin
            state     <= state_next;
            swap_done <= swap_next;
            if (state == PENDING && bus.frame_start)
                active_page <= !active_page;
            copy_cnt <= (state == COPY) ? copy_cnt + 1'b1 : '0;
        end
    end

    // Registered coefficient read; holds when no read strobe.
    always_ff @(posedge clk) begin
        if (reset)
            coef_bits <= '0;
        else if (bus.rd_en)
            coef_bits <= rd_hit ? rd_word : '0;
    end

    assign bus.coef_bits   = coef_bits;
    assign bus.ld_ready    = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.active_page = active_page;
    assign bus.swap_done   = swap_done;
    assign state_dbg       = state;

endmodule

// File: tb/tb_coef_bank.sv
// Self-checking bench for coef_bank against a full-tap, two-page reference model.
module tb_coef_bank;
    import coef_pkg::*;

    localparam int ORDER       = 39;
    localparam int TAPS        = 40;
    localparam int STORE_N     = 20;
    localparam int N_SETS      = 4;
    localparam int COPY_CYCLES = 80;

    logic        clk = 1'b0;
    logic        reset;
    coef_state_e state_dbg;

    coef_bank_if #(.COEF_W(16), .ADDR_W(6), .SET_W(2)) bus ();

    coef_bank #(.COEF_W(16), .ORDER(ORDER), .ADDR_W(6), .N_SETS(N_SETS),
                .SYMMETRIC(1)) dut (
        .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: every tap of every set for both pages.
    int model [2][N_SETS][TAPS];
    int act;
    int n_checks = 0;
    int n_pass   = 0;

    localparam int DEF_TABLE [20] = '{-360, -383, -550, -730, -906, -1061, -1173,
        -1222, -1193, -1073, -858, -552, -168, 272, 741, 1206, 1631, 1984, 2237, 2369};

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_read(input int s, input int a);
        if (a > ORDER || s >= N_SETS) return 0;
        return model[act][s][a];
    endfunction

    task automatic do_read(input int s, input int a);
        int exp;
        exp = model_read(s, a);
        bus.rd_en   = 1'b1;
        bus.rd_set  = 2'(s);
        bus.rd_addr = 6'(a);
        tick();
        bus.rd_en = 1'b0;
        check_val($sformatf("rd s%0d a%0d", s, a), int'(bus.coef_bits), exp);
    endtask

    task automatic do_load(input int s, input int a, input int d);
        bus.ld_valid = 1'b1;
        bus.ld_set   = 2'(s);
        bus.ld_addr  = 6'(a);
        bus.ld_data  = 16'(d);
        tick();
        bus.ld_valid = 1'b0;
        if (a < STORE_N && s < N_SETS) begin
            model[1-act][s][a]         = d;
            model[1-act][s][ORDER - a] = d;
        end
    endtask

    // commit, optional PENDING checks, frame_start swap, then time the copy-back.
    task automatic do_swap(input int pre_wait, input bit rd_in_swap, input int s,
                           input int a, input bit try_load, input bit fs_with_commit);
        int old_val, busy_cycles, pulses;
        bus.commit      = 1'b1;
        bus.frame_start = fs_with_commit;
        tick();
        bus.commit      = 1'b0;
        bus.frame_start = 1'b0;
        check_val("pending busy", int'(bus.busy), 1);
        check_val("pending no swap", int'(bus.active_page), act);
        if (try_load) begin
            bus.ld_valid = 1'b1;
            bus.ld_set   = 2'd1;
            bus.ld_addr  = 6'd0;
            bus.ld_data  = 16'sd5;
            check_val("pending ld_ready", int'(bus.ld_ready), 0);
            tick();
            bus.ld_valid = 1'b0;
        end
        repeat (pre_wait) tick();
        old_val = model_read(s, a);
        bus.frame_start = 1'b1;
        if (rd_in_swap) begin
            bus.rd_en   = 1'b1;
            bus.rd_set  = 2'(s);
            bus.rd_addr = 6'(a);
        end
        tick();
        bus.frame_start = 1'b0;
        bus.rd_en       = 1'b0;
        act = 1 - act;
        model[1-act] = model[act];
        check_val("swap page", int'(bus.active_page), act);
        busy_cycles = 0;
        pulses      = 0;
        if (rd_in_swap) begin
            check_val("swap cycle rd old", int'(bus.coef_bits), old_val);
            busy_cycles = 1;
            do_read(s, a);
        end
        while (bus.busy && busy_cycles < 200) begin
            busy_cycles++;
            pulses += int'(bus.swap_done);
            tick();
        end
        check_val("copy busy cycles", busy_cycles, COPY_CYCLES);
        check_val("early swap_done", pulses, 0);
        check_val("swap_done pulse", int'(bus.swap_done), 1);
        check_val("ld_ready after copy", int'(bus.ld_ready), 1);
        tick();
        check_val("swap_done cleared", int'(bus.swap_done), 0);
    endtask

    initial begin
        int op, s, a, d;
        act = 0;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N_SETS; k++)
                for (int t = 0; t < TAPS; t++)
                    model[p][k][t] = (t < 20) ? DEF_TABLE[t] : DEF_TABLE[ORDER - t];

        reset           = 1'b1;
        bus.rd_en       = 1'b0;
        bus.rd_set      = '0;
        bus.rd_addr     = '0;
        bus.frame_start = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_set      = '0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.commit      = 1'b0;
        repeat (3) tick();
        check_val("rst coef_bits", int'(bus.coef_bits), 0);
        check_val("rst active_page", int'(bus.active_page), 0);
        check_val("rst busy", int'(bus.busy), 0);
        check_val("rst swap_done", int'(bus.swap_done), 0);
        check_val("rst ld_ready", int'(bus.ld_ready), 1);
        check_val("rst state", int'(state_dbg == IDLE), 1);
        reset = 1'b0;
        tick();

        // Default contents, fold boundary and out-of-range tap.
        do_read(0, 0);
        check_val("default a0", int'(bus.coef_bits), -360);
        do_read(0, 19);
        check_val("default a19", int'(bus.coef_bits), 2369);
        do_read(0, 20);
        do_read(0, 39);
        check_val("default a39", int'(bus.coef_bits), -360);
        do_read(0, 40);
        tick();
        check_val("hold without rd_en", int'(bus.coef_bits), 0);

        // Load, blocked PENDING load, read in swap cycle.
        do_load(1, 0, 1000);
        do_swap(2, 1'b1, 1, 0, 1'b1, 1'b0);
        do_read(1, 39);
        check_val("set1 a39 new", int'(bus.coef_bits), 1000);
        do_read(0, 0);

        // commit with frame_start in IDLE must not swap.
        do_load(1, 1, 777);
        do_swap(3, 1'b0, 0, 0, 1'b0, 1'b1);
        do_read(1, 0);
        check_val("set1 a0 kept", int'(bus.coef_bits), 1000);
        do_read(1, 1);
        do_read(1, 38);

        // Randomised loads, reads and swaps.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            s  = $urandom_range(0, 3);
            if (op <= 1) begin
                a = $urandom_range(0, 25);
                d = int'($urandom_range(0, 65535)) - 32768;
                do_load(s, a, d);
            end else if (op == 2) begin
                do_read(s, $urandom_range(0, 45));
            end else begin
                do_swap($urandom_range(0, 3), 1'($urandom_range(0, 1)), s,
                        $urandom_range(0, 45), 1'b0, 1'b0);
            end
        end
        for (int t = 0; t < TAPS; t += 7)
            do_read(t % N_SETS, t);

        // Reset in the middle of the copy-back.
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        act = 1 - act;
        repeat (10) tick();
        do_read(0, 19);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid-copy rst busy", int'(bus.busy), 0);
        check_val("mid-copy rst page", int'(bus.active_page), 0);
        check_val("mid-copy rst ld_ready", int'(bus.ld_ready), 1);
        check_val("mid-copy rst coef", int'(bus.coef_bits), 0);
        check_val("mid-copy rst swap_done", int'(bus.swap_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
